// File: rtl/tanimoto_cmp.sv
// Tanimoto similarity comparator: aligns tagged items with upstream popcounts and tests
// C/(A+B-C) >= T/2^THRESHOLD_WIDTH by cross-multiplication over three register stages.
module tanimoto_cmp #(
   parameter int unsigned VECTOR_WIDTH    = 920,
   parameter int unsigned CNT_LATENCY     = 4,
   parameter int unsigned THRESHOLD_WIDTH = 8,
   parameter int unsigned ID_WIDTH        = 16,
   localparam int unsigned CW             = $clog2(VECTOR_WIDTH) + 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_Valid,
   input  logic [CW-1:0]              i_CntA,
   input  logic [CW-1:0]              i_CntB,
   input  logic [CW-1:0]              i_CntAnd,
   input  logic [THRESHOLD_WIDTH-1:0] i_Threshold,
   input  logic                       i_IdClear,
   output logic                       o_Valid,
   output logic                       o_Hit,
   output logic                       o_Err,
   output logic [ID_WIDTH-1:0]        o_Id
);

   localparam int unsigned UW = CW + 1;
   localparam int unsigned PW = CW + THRESHOLD_WIDTH + 1;

   // ID counter
   logic [ID_WIDTH-1:0] id_q, id_d, entry_id;

   always_comb begin
      id_d     = id_q;
      entry_id = id_q;
      if (i_IdClear) begin
         entry_id = '0;
         id_d     = i_Valid ? ID_WIDTH'(1) : '0;
      end else if (i_Valid) begin
         id_d = id_q + ID_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         id_q <= '0;
      end else begin
         id_q <= id_d;
      end
   end

   // Alignment line: the last entry meets the counts its vectors produced.
   logic                line_vld_q [CNT_LATENCY];
   logic [ID_WIDTH-1:0] line_id_q  [CNT_LATENCY];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < CNT_LATENCY; i++) begin
            line_vld_q[i] <= 1'b0;
            line_id_q[i]  <= '0;
         end
      end else begin
         line_vld_q[0] <= i_Valid;
         line_id_q[0]  <= entry_id;
         for (int unsigned i = 1; i < CNT_LATENCY; i++) begin
            line_vld_q[i] <= line_vld_q[i-1];
            line_id_q[i]  <= line_id_q[i-1];
         end
      end
   end

   // Stage S1: union count, consistency check, threshold capture
   logic                       s1_vld_q, s1_err_q, s1_err_d;
   logic [ID_WIDTH-1:0]        s1_id_q;
   logic [UW-1:0]              s1_u_q, s1_u_d;
   logic [CW-1:0]              s1_c_q;
   logic [THRESHOLD_WIDTH-1:0] s1_t_q;

   always_comb begin
      s1_u_d   = {1'b0, i_CntA} + {1'b0, i_CntB} - {1'b0, i_CntAnd};
      s1_err_d = (i_CntAnd > i_CntA) || (i_CntAnd > i_CntB);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vld_q <= 1'b0;
         s1_err_q <= 1'b0;
         s1_id_q  <= '0;
         s1_u_q   <= '0;
         s1_c_q   <= '0;
         s1_t_q   <= '0;
      end else begin
         s1_vld_q <= line_vld_q[CNT_LATENCY-1];
         s1_err_q <= s1_err_d;
         s1_id_q  <= line_id_q[CNT_LATENCY-1];
         s1_u_q   <= s1_u_d;
         s1_c_q   <= i_CntAnd;
         s1_t_q   <= i_Threshold;
      end
   end

   // Stage S2: cross-multiplied operands, full width
   logic                s2_vld_q, s2_err_q, s2_unz_q;
   logic [ID_WIDTH-1:0] s2_id_q;
   logic [PW-1:0]       s2_l_q, s2_r_q, s2_l_d, s2_r_d;

   always_comb begin
      s2_l_d = {1'b0, s1_c_q, {THRESHOLD_WIDTH{1'b0}}};
      s2_r_d = PW'(s1_u_q) * PW'(s1_t_q);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_vld_q <= 1'b0;
         s2_err_q <= 1'b0;
         s2_unz_q <= 1'b0;
         s2_id_q  <= '0;
         s2_l_q   <= '0;
         s2_r_q   <= '0;
      end else begin
         s2_vld_q <= s1_vld_q;
         s2_err_q <= s1_err_q;
         s2_unz_q <= (s1_u_q != '0);
         s2_id_q  <= s1_id_q;
         s2_l_q   <= s2_l_d;
         s2_r_q   <= s2_r_d;
      end
   end

   // Stage S3: decision; hit/err gated by valid so they read 0 on empty slots
   logic                s3_vld_q, s3_hit_q, s3_err_q, s3_hit_d, s3_err_d;
   logic [ID_WIDTH-1:0] s3_id_q;

   always_comb begin
      s3_hit_d = s2_vld_q && s2_unz_q && !s2_err_q && (s2_l_q >= s2_r_q);
      s3_err_d = s2_vld_q && s2_err_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s3_vld_q <= 1'b0;
         s3_hit_q <= 1'b0;
         s3_err_q <= 1'b0;
         s3_id_q  <= '0;
      end else begin
         s3_vld_q <= s2_vld_q;
         s3_hit_q <= s3_hit_d;
         s3_err_q <= s3_err_d;
         s3_id_q  <= s2_id_q;
      end
   end

   assign o_Valid = s3_vld_q;
   assign o_Hit   = s3_hit_q;
   assign o_Err   = s3_err_q;
   assign o_Id    = s3_id_q;

endmodule

// File: tb/tb_tanimoto_cmp.sv
// Directed bench for tanimoto_cmp: vector table plus ID, reset and wrap sequences,
// checked against a queue of expected tagged results with exact due cycles.
module tb_tanimoto_cmp;

   localparam int LAT = 4;

   typedef struct packed {
      logic [10:0] a;
      logic [10:0] b;
      logic [10:0] c;
      logic [7:0]  t;
   } cnt_t;

   typedef struct {
      logic [10:0] a;
      logic [10:0] b;
      logic [10:0] c;
      logic [7:0]  t;
      logic        hit;
      logic        err;
   } vec_t;

   typedef struct {
      logic [15:0] id;
      logic        hit;
      logic        err;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_Valid;
   logic [10:0] i_CntA, i_CntB, i_CntAnd;
   logic [7:0]  i_Threshold;
   logic        i_IdClear;
   logic        o_Valid, o_Hit, o_Err;
   logic [15:0] o_Id;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [15:0] exp_id = 16'd0;
   exp_t        q[$];
   vec_t        vecs[12];
   vec_t        zero_v;
   cnt_t        st;
   cnt_t        dl[LAT];

   tanimoto_cmp dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_Valid     (i_Valid),
      .i_CntA      (i_CntA),
      .i_CntB      (i_CntB),
      .i_CntAnd    (i_CntAnd),
      .i_Threshold (i_Threshold),
      .i_IdClear   (i_IdClear),
      .o_Valid     (o_Valid),
      .o_Hit       (o_Hit),
      .o_Err       (o_Err),
      .o_Id        (o_Id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the upstream popcount latency: counts and threshold arrive LAT cycles later.
   always @(posedge clk) begin
      dl[0] <= st;
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
   end

   assign i_CntA      = dl[LAT-1].a;
   assign i_CntB      = dl[LAT-1].b;
   assign i_CntAnd    = dl[LAT-1].c;
   assign i_Threshold = dl[LAT-1].t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input int a, input int b, input int c, input int t,
                               input bit h, input bit e);
      vec_t v;
      v.a = 11'(a);
      v.b = 11'(b);
      v.c = 11'(c);
      v.t = 8'(t);
      v.hit = h;
      v.err = e;
      return v;
   endfunction

   always @(negedge clk) begin
      logic ev;
      exp_t e;
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("o_Valid", 32'(o_Valid), 32'(ev));
      if (!o_Valid) begin
         chk("o_Hit idle", 32'(o_Hit), 32'd0);
         chk("o_Err idle", 32'(o_Err), 32'd0);
      end
      if (!rstn) chk("o_Id reset", 32'(o_Id), 32'd0);
      if (ev) begin
         e = q.pop_front();
         if (o_Valid) begin
            chk("o_Id", 32'(o_Id), 32'(e.id));
            chk("o_Hit", 32'(o_Hit), 32'(e.hit));
            chk("o_Err", 32'(o_Err), 32'(e.err));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input vec_t v, input logic clr);
      exp_t e;
      i_Valid   = 1'b1;
      i_IdClear = clr;
      st.a = v.a;
      st.b = v.b;
      st.c = v.c;
      st.t = v.t;
      if (clr) begin
         e.id   = 16'd0;
         exp_id = 16'd1;
      end else begin
         e.id   = exp_id;
         exp_id = exp_id + 16'd1;
      end
      e.hit = v.hit;
      e.err = v.err;
      e.due = cyc + LAT + 3;
      q.push_back(e);
      tick();
   endtask

   task automatic idle(input int n);
      i_Valid   = 1'b0;
      i_IdClear = 1'b0;
      st        = '0;
      repeat (n) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = mk(100, 100,  80, 154, 1, 0);
      vecs[1]  = mk(100, 100,  70, 154, 0, 0);
      vecs[2]  = mk(  3,   3,   2, 128, 1, 0);
      vecs[3]  = mk(  0,   0,   0, 128, 0, 0);
      vecs[4]  = mk(  5,  50,   6, 154, 0, 1);
      vecs[5]  = mk( 50,   5,   6, 154, 0, 1);
      vecs[6]  = mk(100, 100,  20, 154, 0, 0);
      vecs[7]  = mk(100, 100,  20,  26, 1, 0);
      vecs[8]  = mk(920, 920, 920, 255, 1, 0);
      vecs[9]  = mk( 10,  20,  10, 128, 1, 0);
      vecs[10] = mk( 10,  20,   9, 128, 0, 0);
      vecs[11] = mk(  0,   5,   0,   0, 1, 0);
      zero_v   = mk(0, 0, 0, 0, 0, 0);

      rstn      = 1'b0;
      i_Valid   = 1'b0;
      i_IdClear = 1'b0;
      st        = '0;
      repeat (3) tick();
      rstn = 1'b1;
      idle(2);

      // Back-to-back table: hit/miss, ties, empty, inconsistent counts, threshold switch
      for (int i = 0; i < 12; i++) issue(vecs[i], 1'b0);
      idle(10);

      // Clear alone, three items, then clear together with the fourth
      i_IdClear = 1'b1;
      exp_id    = 16'd0;
      tick();
      i_IdClear = 1'b0;
      for (int i = 0; i < 3; i++) issue(vecs[i], 1'b0);
      issue(vecs[9], 1'b1);
      issue(vecs[10], 1'b0);
      idle(10);

      // Reset pulse with five items in flight
      for (int i = 0; i < 5; i++) issue(vecs[i], 1'b0);
      i_Valid = 1'b0;
      st      = '0;
      rstn    = 1'b0;
      q.delete();
      exp_id  = 16'd0;
      tick();
      rstn = 1'b1;
      idle(2);
      issue(vecs[0], 1'b0);
      idle(12);

      // ID wrap: 65536 items after a clear, next one carries ID 0 again
      i_IdClear = 1'b1;
      exp_id    = 16'd0;
      tick();
      i_IdClear = 1'b0;
      for (int i = 0; i < 65536; i++) issue(zero_v, 1'b0);
      issue(vecs[2], 1'b0);
      idle(12);

      chk("queue drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
